// File: rtl/output_if_pkg.sv
// Shared definitions for the result transmit path.
//   BYTE_W          : width of one serialized byte
//   tx_ser_state_t  : states of the result serializer FSM
package output_if_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_ACK  = 3'd3,
        WAIT_DONE = 3'd4
    } tx_ser_state_t;

endpackage

// File: rtl/result_tx_serializer_word_fifo.sv
// word_fifo: small synchronous FIFO with first-word fall-through read data.
// Ports:
//   clk, reset        : clock, synchronous active-low reset
//   push, wr_data     : write request and data (ignored while full)
//   pop               : read request (ignored while empty)
//   rd_data           : head-of-queue word, valid whenever empty is 0
//   count, full, empty: occupancy status, all derived from registered state
module word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    // A full FIFO refuses a push even when a pop happens on the same edge,
    // because the producer saw ready deasserted for this cycle.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr_reg];

    // Storage carries no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // Pointers are exactly PTR_W bits wide, so they wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/result_tx_serializer.sv
// result_tx_serializer: buffers result words and feeds them to uart_tx one
// byte at a time using a start-pulse / busy handshake.
// Ports:
//   clk, reset                 : clock, synchronous active-low reset
//   result_data, result_valid  : result word from the processing core
//   result_ready               : FIFO can take a word this cycle
//   tx_data, tx_start          : byte and one-cycle start pulse to uart_tx
//   tx_busy                    : uart_tx is transmitting
//   fifo_count                 : words waiting in the FIFO
//   busy                       : a word is in flight or words are queued
module result_tx_serializer
    import output_if_pkg::*;
#(
    parameter int WORD_BYTES = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int MSB_FIRST  = 0
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [BYTE_W*WORD_BYTES-1:0]      result_data,
    input  logic                              result_valid,
    output logic                              result_ready,
    output logic [BYTE_W-1:0]                 tx_data,
    output logic                              tx_start,
    input  logic                              tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]       fifo_count,
    output logic                              busy
);

    localparam int W     = BYTE_W * WORD_BYTES;
    localparam int IDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    tx_ser_state_t      state_reg;
    logic [W-1:0]       word_reg;
    logic [IDX_W-1:0]   byte_idx_reg;
    logic [BYTE_W-1:0]  tx_data_reg;
    logic               tx_start_reg;

    logic [W-1:0]       fifo_rd_data;
    logic               fifo_full;
    logic               fifo_empty;
    logic               fifo_pop;
    logic [IDX_W-1:0]   sel_idx;
    logic [BYTE_W-1:0]  sel_byte;
    logic [BYTE_W-1:0]  word_bytes [WORD_BYTES];
    logic               last_byte;

    // Only an idle FSM takes the next word out of the FIFO.
    assign fifo_pop = (state_reg == IDLE) && !fifo_empty;

    word_fifo #(
        .WIDTH (W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (result_valid),
        .wr_data (result_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Split the held word into bytes; byte 0 is bits 7:0.
    generate
        for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_bytes
            assign word_bytes[gi] = word_reg[gi*BYTE_W +: BYTE_W];
        end
    endgenerate

    always_comb begin
        sel_idx = byte_idx_reg;
        if (MSB_FIRST != 0) begin
            sel_idx = IDX_W'(WORD_BYTES - 1) - byte_idx_reg;
        end
    end

    assign sel_byte     = word_bytes[sel_idx];
    assign last_byte    = (byte_idx_reg == IDX_W'(WORD_BYTES - 1));
    assign result_ready = !fifo_full;
    assign tx_data      = tx_data_reg;
    assign tx_start     = tx_start_reg;
    assign busy         = (state_reg != IDLE) || !fifo_empty;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg    <= IDLE;
            word_reg     <= '0;
            byte_idx_reg <= '0;
            tx_data_reg  <= '0;
            tx_start_reg <= 1'b0;
        end else begin
            tx_start_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (!fifo_empty) begin
                        word_reg     <= fifo_rd_data;
                        byte_idx_reg <= '0;
                        state_reg    <= LOAD;
                    end
                end
                LOAD: begin
                    // tx_data only changes here, so it is stable for the
                    // whole start/ack/done handshake that follows.
                    tx_data_reg  <= sel_byte;
                    tx_start_reg <= 1'b1;
                    state_reg    <= START;
                end
                START: begin
                    // tx_busy is not looked at here; a busy left over from the
                    // previous byte must not be taken as the acknowledge.
                    state_reg <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy) begin
                        state_reg <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        if (last_byte) begin
                            state_reg <= IDLE;
                        end else begin
                            byte_idx_reg <= byte_idx_reg + IDX_W'(1);
                            state_reg    <= LOAD;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_result_tx_serializer.sv
module tb_result_tx_serializer;

    logic        clk = 1'b0;
    logic        reset;

    // Instance a: 4 bytes, LSB first. b: 4 bytes, MSB first. c: 2 bytes, LSB first.
    logic [31:0] data_a, data_b;
    logic [15:0] data_c;
    logic        valid_a, valid_b, valid_c;
    logic        ready_a, ready_b, ready_c;
    logic [7:0]  txd_a, txd_b, txd_c;
    logic        start_a, start_b, start_c;
    logic        txbusy_a, txbusy_b, txbusy_c;
    logic [2:0]  cnt_a, cnt_b, cnt_c;
    logic        busy_a, busy_b, busy_c;
    logic        force_a;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    result_tx_serializer #(.WORD_BYTES(4), .FIFO_DEPTH(4), .MSB_FIRST(0)) dut_a (
        .clk(clk), .reset(reset), .result_data(data_a), .result_valid(valid_a),
        .result_ready(ready_a), .tx_data(txd_a), .tx_start(start_a), .tx_busy(txbusy_a),
        .fifo_count(cnt_a), .busy(busy_a));

    result_tx_serializer #(.WORD_BYTES(4), .FIFO_DEPTH(4), .MSB_FIRST(1)) dut_b (
        .clk(clk), .reset(reset), .result_data(data_b), .result_valid(valid_b),
        .result_ready(ready_b), .tx_data(txd_b), .tx_start(start_b), .tx_busy(txbusy_b),
        .fifo_count(cnt_b), .busy(busy_b));

    result_tx_serializer #(.WORD_BYTES(2), .FIFO_DEPTH(4), .MSB_FIRST(0)) dut_c (
        .clk(clk), .reset(reset), .result_data(data_c), .result_valid(valid_c),
        .result_ready(ready_c), .tx_data(txd_c), .tx_start(start_c), .tx_busy(txbusy_c),
        .fifo_count(cnt_c), .busy(busy_c));

    // UART models: busy rises the cycle after tx_start and stays high 10 cycles.
    int u_a = 0, u_b = 0, u_c = 0;
    assign txbusy_a = force_a || (u_a != 0);
    assign txbusy_b = (u_b != 0);
    assign txbusy_c = (u_c != 0);

    // Byte logs, captured at the edge that ends each tx_start cycle.
    logic [7:0] log_a [0:127];
    logic [7:0] log_b [0:15];
    logic [7:0] log_c [0:15];
    int n_a = 0, n_b = 0, n_c = 0;
    logic prev_a = 1'b0, prev_b = 1'b0, prev_c = 1'b0;
    logic dbl_a = 1'b0, dbl_b = 1'b0, dbl_c = 1'b0;

    always @(posedge clk) begin
        if (!reset) u_a <= 0;
        else if (start_a) u_a <= 10;
        else if (u_a != 0) u_a <= u_a - 1;
        if (start_a && n_a < 128) begin
            log_a[n_a] <= txd_a;
            n_a <= n_a + 1;
        end
        prev_a <= start_a;
        if (start_a && prev_a) dbl_a <= 1'b1;
    end

    always @(posedge clk) begin
        if (!reset) u_b <= 0;
        else if (start_b) u_b <= 10;
        else if (u_b != 0) u_b <= u_b - 1;
        if (start_b && n_b < 16) begin
            log_b[n_b] <= txd_b;
            n_b <= n_b + 1;
        end
        prev_b <= start_b;
        if (start_b && prev_b) dbl_b <= 1'b1;
    end

    always @(posedge clk) begin
        if (!reset) u_c <= 0;
        else if (start_c) u_c <= 10;
        else if (u_c != 0) u_c <= u_c - 1;
        if (start_c && n_c < 16) begin
            log_c[n_c] <= txd_c;
            n_c <= n_c + 1;
        end
        prev_c <= start_c;
        if (start_c && prev_c) dbl_c <= 1'b1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
            $display("check %-18s observed=%0h expected=%0h ok", tag, obs, exp);
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_a(input logic [31:0] d);
        logic acc;
        acc = 1'b0;
        valid_a = 1'b1;
        data_a  = d;
        for (int g = 0; g < 500; g++) begin
            acc = ready_a;
            tick();
            if (acc) break;
        end
        valid_a = 1'b0;
        check("push_accepted", {63'd0, acc}, 64'd1);
    endtask

    int base;
    int k;
    logic [31:0] w;

    initial begin
        reset = 1'b0; force_a = 1'b0;
        valid_a = 0; valid_b = 0; valid_c = 0;
        data_a = '0; data_b = '0; data_c = '0;
        tick(); tick();

        // Reset state
        check("rst_ready_a", {63'd0, ready_a}, 64'd1);
        check("rst_ready_b", {63'd0, ready_b}, 64'd1);
        check("rst_ready_c", {63'd0, ready_c}, 64'd1);
        check("rst_busy_abc", {61'd0, busy_a, busy_b, busy_c}, 64'd0);
        check("rst_count_abc", {55'd0, cnt_a, cnt_b, cnt_c}, 64'd0);
        check("rst_start_abc", {61'd0, start_a, start_b, start_c}, 64'd0);
        check("rst_txdata_abc", {40'd0, txd_a, txd_b, txd_c}, 64'd0);
        reset = 1'b1;
        tick();

        // One word into each instance: LSB first, MSB first, two-byte word
        data_a = 32'hDEADBEEF; data_b = 32'hDEADBEEF; data_c = 16'h1234;
        valid_a = 1; valid_b = 1; valid_c = 1;
        tick();
        valid_a = 0; valid_b = 0; valid_c = 0;
        check("t1_count_after_push", {61'd0, cnt_a}, 64'd1);
        tick();
        check("t1_no_start_in_load", {63'd0, start_a}, 64'd0);
        tick();
        check("t1_start_latency", {63'd0, start_a}, 64'd1);
        check("t1_first_byte_a", {56'd0, txd_a}, 64'hEF);
        check("t2_first_byte_b", {56'd0, txd_b}, 64'hDE);
        check("t6_first_byte_c", {56'd0, txd_c}, 64'h34);
        for (k = 0; k < 400 && (busy_a || busy_b || busy_c); k++) tick();
        check("t1_drain_in_time", {63'd0, (k < 400)}, 64'd1);
        check("t1_nbytes_a", 64'(n_a), 64'd4);
        check("t1_bytes_a", {32'd0, log_a[0], log_a[1], log_a[2], log_a[3]}, 64'hEFBEADDE);
        check("t2_nbytes_b", 64'(n_b), 64'd4);
        check("t2_bytes_b", {32'd0, log_b[0], log_b[1], log_b[2], log_b[3]}, 64'hDEADBEEF);
        check("t6_nbytes_c", 64'(n_c), 64'd2);
        check("t6_bytes_c", {48'd0, log_c[0], log_c[1]}, 64'h3412);
        check("t1_busy_after", {63'd0, busy_a}, 64'd0);

        // tx_busy held high: five pushes, one word goes to the shift register
        force_a = 1'b1;
        base = n_a;
        valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_a = 32'hA0 + 32'(i);
            tick();
        end
        check("t3_count_full", {61'd0, cnt_a}, 64'd4);
        check("t3_ready_low", {63'd0, ready_a}, 64'd0);
        data_a = 32'h00000BAD;
        tick(); tick(); tick();
        valid_a = 1'b0;
        check("t3_full_ignores", {61'd0, cnt_a}, 64'd4);
        check("t3_one_start", 64'(n_a - base), 64'd1);
        check("t3_first_byte", {56'd0, txd_a}, 64'hA0);
        force_a = 1'b0;
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Push coinciding with an IDLE pop at count 2, then order across wrap
        base = n_a;
        valid_a = 1'b1;
        data_a = 32'd1; tick();
        data_a = 32'd2; tick();
        data_a = 32'd3; tick();
        valid_a = 1'b0;
        check("t4_count_two", {61'd0, cnt_a}, 64'd2);
        for (k = 0; k < 200 && (n_a - base) < 4; k++) tick();
        check("t4_word1_started", 64'(n_a - base), 64'd4);
        // Last byte's busy falls 10 cycles after its start; IDLE pop 2 cycles later.
        repeat (11) tick();
        check("t4_pre_pop_count", {61'd0, cnt_a}, 64'd2);
        valid_a = 1'b1; data_a = 32'd4;
        tick();
        valid_a = 1'b0;
        check("t4_push_pop_count", {61'd0, cnt_a}, 64'd2);
        for (int i = 5; i <= 8; i++) push_a(32'(i));
        for (k = 0; k < 2000 && busy_a; k++) tick();
        check("t4_drain_in_time", {63'd0, (k < 2000)}, 64'd1);
        check("t4_nbytes", 64'(n_a - base), 64'd32);
        for (int i = 0; i < 8; i++) begin
            w = {log_a[base + 4*i + 3], log_a[base + 4*i + 2],
                 log_a[base + 4*i + 1], log_a[base + 4*i]};
            check($sformatf("t4_word%0d", i + 1), {32'd0, w}, 64'(i + 1));
        end

        // Reset in WAIT_DONE of byte 2 with two words queued
        base = n_a;
        valid_a = 1'b1;
        data_a = 32'h11223344; tick();
        data_a = 32'h55667788; tick();
        data_a = 32'h99AABBCC; tick();
        valid_a = 1'b0;
        for (k = 0; k < 200 && (n_a - base) < 2; k++) tick();
        check("t5_byte2_started", 64'(n_a - base), 64'd2);
        tick(); tick(); tick();
        check("t5_pre_reset_count", {61'd0, cnt_a}, 64'd2);
        check("t5_pre_reset_byte", {56'd0, txd_a}, 64'h33);
        reset = 1'b0;
        tick();
        check("t5_start_cleared", {63'd0, start_a}, 64'd0);
        check("t5_txdata_cleared", {56'd0, txd_a}, 64'd0);
        check("t5_count_cleared", {61'd0, cnt_a}, 64'd0);
        check("t5_busy_cleared", {63'd0, busy_a}, 64'd0);
        reset = 1'b1;
        repeat (40) tick();
        check("t5_no_more_starts", 64'(n_a - base), 64'd2);
        check("t5_idle_ready", {63'd0, ready_a}, 64'd1);

        // tx_start never high on two consecutive cycles
        check("no_double_start", {61'd0, dbl_a, dbl_b, dbl_c}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
